// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states and address legality rules.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte addresses select a word through bits [DEPTH_LOG2+WORD_LSB-1:WORD_LSB].
    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned MAX_ADDR_W = 64;

    function automatic logic is_aligned(input logic [MAX_ADDR_W-1:0] addr);
        return addr[WORD_LSB-1:0] == '0;
    endfunction

    function automatic logic in_range(input logic [MAX_ADDR_W-1:0] addr,
                                      input int unsigned depth_log2);
        return (addr >> (depth_log2 + WORD_LSB)) == '0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the main controller and the memory responder.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, asynchronous read by word index.
module mem_array #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, inserts WAIT_CYCLES wait states,
// then commits the access and pulses a one-cycle response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic                  commit;
    logic                  c_we;
    logic [ADDR_W-1:0]     c_addr;
    logic [DATA_W-1:0]     c_wdata;
    logic                  c_legal;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic                  arr_we;
    logic [DATA_W-1:0]     arr_rdata;

    assign bus.req_ready = (state == IDLE);

    // With zero wait states the commit edge is the accept edge, so the live
    // request fields feed the array instead of the not-yet-latched copies.
    always_comb begin
        if (state == IDLE) begin
            c_we    = bus.req_we;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            commit  = bus.req_valid && (WAIT_CYCLES == 0);
        end else begin
            c_we    = we_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            commit  = (state == WAIT) && (cnt == CW'(1));
        end
        c_legal = is_aligned(MAX_ADDR_W'(c_addr)) && in_range(MAX_ADDR_W'(c_addr), DEPTH_LOG2);
        c_idx   = c_addr[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];
        arr_we  = commit && c_we && c_legal && !reset;
    end

    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (c_idx),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (commit) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= !c_legal;
                if (!c_legal) begin
                    bus.rsp_rdata <= '0;
                end else if (!c_we) begin
                    bus.rsp_rdata <= arr_rdata;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        cnt      <= CW'(WAIT_CYCLES);
                        bus.busy <= 1'b1;
                        state    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle processor's shared instruction/data memory port.
- The main controller FSM issues single-word read/write requests.
- This block accepts one request at a time, inserts a fixed number of wait states, then returns read data or a write acknowledge with an error flag.
- Sits between the datapath address/write-data muxes and the unified word-addressed storage array.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte address width.
- DEPTH_LOG2, 6, log2 of the number of words (default 64 words, byte range 0x000–0x0FC).
- WAIT_CYCLES, 2, wait-state cycles between request acceptance and response; 0 is legal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address of the access.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  high when a request is accepted this cycle.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  access faulted, valid with rsp_valid.
- busy  out  1  transaction in flight (not IDLE).

Behaviour:
- Reset (sync, active-high):
  - state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1 (combinational, IDLE only).
  - On req_valid, latch we/addr/wdata and load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - Decrement the counter every cycle.
  - Go to RESP on the cycle the counter is 1.
  - Spends exactly WAIT_CYCLES cycles in WAIT.
- RESP (one cycle):
  - rsp_valid = 1, then return to IDLE.
  - No backpressure; the requester must sample the response in this cycle.
- Commit point:
  - On the edge entering RESP, a legal write updates the array.
  - On the same edge, a legal read registers the array word into rsp_rdata.
- Latency: rsp_valid rises WAIT_CYCLES + 1 cycles after the accepting edge. Throughput is one access per WAIT_CYCLES + 2 cycles.
- Legality and errors:
  - Misaligned (addr[1:0] != 0) or out-of-range (any bit above DEPTH_LOG2+1 set) → rsp_err = 1, rsp_rdata = 0, no array write.
- rsp_rdata/rsp_err hold their last values outside RESP. Only rsp_valid qualifies them.
- Inputs are ignored outside IDLE; latched request fields must not change mid-transaction.
- Reset mid-transaction (WAIT or RESP): abort to IDLE. A pending write is dropped if reset is asserted on the commit edge. No rsp_valid is produced.
- req_valid held high continuously → back-to-back accepts, one in each IDLE cycle.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1 bit.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding localparams IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  - the word index slice rule;
  - the alignment check.
- One sub-module, mem_array: single-port storage, synchronous write with we, asynchronous read by word index, 2**DEPTH_LOG2 × DATA_W.
- mem_responder owns the FSM, the counter, and the response registers.

Test Plan:
- Reset, then WAIT_CYCLES=2: write 0xDEADBEEF @0x010 → req_ready high in the accept cycle only, rsp_valid pulses 3 cycles later, rsp_err = 0, busy high for 3 cycles.
- Read @0x010 after that write → rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid exactly 1 cycle wide.
- Write 0x12345678 @0x012 (misaligned), then read @0x010 → first response rsp_err = 1, rdata 0; read returns 0xDEADBEEF (no corruption). Read @0x100 → rsp_err = 1.
- WAIT_CYCLES=0 build, req_valid held high with reads @0x000, @0x004 → rsp_valid every 2nd cycle, 1 cycle after each accept.
- Reset asserted during WAIT of write 0xCAFEF00D @0x020 → no rsp_valid, state IDLE next cycle, subsequent read @0x020 returns the prior value.
- Request with req_valid pulsed during WAIT/RESP (addr 0x030) → ignored, no extra response, latched address unchanged.
